spi_slave: RTL
==============

Name: spi_slave

Overview:
- SPI slave endpoint for the other end of the SPI_Master link. Runs entirely in the system clock domain.
- Oversamples SCK, CS_n and MOSI through 2-flop synchronizers. Deserialises MOSI into bytes and serialises a user-supplied byte onto MISO.
- Sits between the SPI pins and on-chip logic, with the same byte/DV handshake style as the master.

Parameters:
- SPI_MODE, 0: CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]; legal values 0-3.
- TX_IDLE_BYTE, 8'hFF: byte shifted out on MISO when no user byte is pending at a byte boundary.

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_TX_Byte  in  8  byte to return on MISO.
- i_TX_DV  in  1  one-cycle valid with i_TX_Byte.
- o_TX_Ready  out  1  holding register empty; can accept i_TX_DV.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Byte valid.
- o_RX_Byte  out  8  last complete byte received on MOSI.
- i_SPI_Clk  in  1  SCK from master (asynchronous).
- i_SPI_CS_n  in  1  chip select, active low (asynchronous).
- i_SPI_MOSI  in  1  serial data from master (asynchronous).
- o_SPI_MISO  out  1  serial data to master.
- o_SPI_MISO_En  out  1  MISO output enable; high while selected, for an external tristate.

Behaviour:
- Reset: o_RX_DV=0, o_RX_Byte=0, o_TX_Ready=1, o_SPI_MISO=0, o_SPI_MISO_En=0. Synchronizers are set to the idle pin levels: SCK=CPOL, CS_n=1, MOSI=0. Holding register is emptied, bit counter=0, FSM=IDLE.
- Rate limit: SCK frequency must be ≤ i_Clk/8 (master CLKS_PER_HALF_BIT ≥ 4).
- Synchronizers: each input passes through FF1→FF2. A third register on SCK and CS_n feeds edge detection (FF2 vs FF3).
- Edge classes:
  - Leading edge: SCK leaves CPOL. Trailing edge: SCK returns to CPOL.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge: the opposite one.
- FSM IDLE:
  - o_SPI_MISO_En=0; SCK edges are ignored.
  - Synced CS_n falling → ACTIVE. On the same cycle: bit counter=0; TX shifter loads the holding byte if pending (holding register freed, o_TX_Ready=1 next cycle), else TX_IDLE_BYTE.
  - o_SPI_MISO = shifter[7] from the next cycle; o_SPI_MISO_En=1.
- FSM ACTIVE:
  - Sample edge: rx_shift <= {rx_shift[6:0], MOSI_sync}; bit counter +1.
  - On the 8th sample: o_RX_Byte <= {rx_shift[6:0], MOSI_sync}, o_RX_DV=1 for exactly one cycle, counter wraps to 0.
  - o_RX_DV rises on the 3rd i_Clk rising edge after the pin-level sample edge.
  - Shift edge, CPHA=0: MISO advances to the next bit.
  - Shift edge, CPHA=1: the first leading edge of each byte presents bit 7; subsequent leading edges advance.
- Byte boundary (8th sample): the TX shifter reloads from the holding register if pending, else TX_IDLE_BYTE. Back-to-back bytes need no CS toggle.
- TX handshake:
  - i_TX_DV with o_TX_Ready=1 captures i_TX_Byte; o_TX_Ready=0 next cycle.
  - i_TX_DV with o_TX_Ready=0 is ignored; the holding byte is unchanged.
  - i_TX_DV on the same cycle as a reload that frees the holding register: the reload takes the old byte, the new byte is captured, and o_TX_Ready stays 0.
- CS_n rising (any time) → IDLE:
  - A partial byte is discarded: no o_RX_DV, bit counter=0, o_SPI_MISO_En=0 next cycle.
  - A byte already moved into the shifter is lost. The holding register is unaffected.
- CS_n rising coincident with the 8th sample edge: the byte completes, and o_RX_DV pulses before returning to IDLE.
- i_Rst mid-transfer: immediate return to reset values; any in-flight byte is dropped without o_RX_DV.

Optional Feature:
- Macro: SPI_SLAVE_TX_UNDERRUN_EN.
- Defined: adds output o_TX_Underrun (1 bit, reset 0). It pulses high for one cycle whenever a shifter load (CS assert or byte boundary) uses TX_IDLE_BYTE because no byte is pending.
- Undefined: the port and its logic are absent. Idle-byte substitution behaves identically.

Test Plan:
- Mode 3, preload 8'hA5, master sends 8'hC1 → o_RX_Byte=8'hC1 with a single o_RX_DV pulse; master receives 8'hA5; o_TX_Ready returns to 1 after the CS fall.
- Mode 0, back-to-back bytes 8'hBE, 8'hEF under one CS with preloads 8'h12, 8'h34 → two o_RX_DV pulses with 8'hBE then 8'hEF; master receives 8'h12 then 8'h34.
- No preload, mode 1, master sends 8'h5A → master receives 8'hFF; o_RX_Byte=8'h5A; with SPI_SLAVE_TX_UNDERRUN_EN, o_TX_Underrun pulses once at the CS fall.
- CS_n deasserted after 5 SCK cycles of 8'hF0 → no o_RX_DV; o_RX_Byte keeps its prior value; the next full byte 8'h3C is received correctly.
- i_TX_DV with 8'h77 while o_TX_Ready=0 (8'h66 pending) → master receives 8'h66; 8'h77 is never sent.
- i_Rst asserted mid-byte in mode 2 → all outputs at reset values next cycle; after release, 8'h81 is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI slave endpoint running in the system clock domain.
// Pins are oversampled through 2-flop synchronizers. MOSI is deserialised into bytes,
// and a user-supplied byte is serialised onto MISO.
// Ports:
//   i_Clk, i_Rst              system clock, synchronous active-high reset
//   i_TX_Byte, i_TX_DV        byte to return on MISO with its one-cycle valid
//   o_TX_Ready                holding register empty
//   o_RX_DV, o_RX_Byte        one-cycle pulse with the last complete received byte
//   i_SPI_Clk, i_SPI_CS_n     SCK and active-low chip select from the master (async)
//   i_SPI_MOSI                serial data from the master (async)
//   o_SPI_MISO, o_SPI_MISO_En serial data to the master and its tristate enable
//   o_TX_Underrun             idle-byte substitution pulse (only with SPI_SLAVE_TX_UNDERRUN_EN)
module spi_slave #(
    parameter int         SPI_MODE     = 0,
    parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    output logic       o_TX_Underrun,
`endif
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);
    localparam logic [1:0] MODE = SPI_MODE[1:0];
    localparam logic CPOL = MODE[1];
    localparam logic CPHA = MODE[0];
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;
    logic [2:0] sck_q, cs_q, cnt_q, cnt_d;
    logic [1:0] mosi_q;
    logic [7:0] rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic [7:0] tx_shift_q, tx_shift_d, hold_q, hold_d;
    logic       rx_dv_q, rx_dv_d, hold_valid_q, hold_valid_d;
    logic       active, leading, trailing, sample, shift, cs_fall, cs_rise, last, load, accept;
    // FF2 is the synchronized level, FF3 its previous value for edge detection
    assign active   = state_q == ACTIVE;
    assign leading  = (sck_q[1] != CPOL) && (sck_q[2] == CPOL);
    assign trailing = (sck_q[1] == CPOL) && (sck_q[2] != CPOL);
    assign sample   = CPHA ? trailing : leading;
    assign shift    = CPHA ? leading : trailing;
    assign cs_fall  = !cs_q[1] && cs_q[2];
    assign cs_rise  = cs_q[1] && !cs_q[2];
    assign last     = active && sample && (cnt_q == 3'd7);
    // a byte finishing as CS rises does not pull a new byte out of the holding register
    assign load     = (!active && cs_fall) || (last && !cs_rise);
    // a reload frees the holding register in the same cycle, so a new byte can be taken
    assign accept   = i_TX_DV && (!hold_valid_q || load);
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_shift_d   = rx_shift_q;
        rx_byte_d    = rx_byte_q;
        rx_dv_d      = 1'b0;
        tx_shift_d   = tx_shift_q;
        hold_valid_d = accept || (hold_valid_q && !load);
        hold_d       = accept ? i_TX_Byte : hold_q;
        if (!active && cs_fall) begin
            state_d = ACTIVE;
            cnt_d   = 3'd0;
        end
        if (active && sample) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_q[1]};
            cnt_d      = cnt_q + 3'd1;
        end
        if (last) begin
            rx_byte_d = {rx_shift_q[6:0], mosi_q[1]};
            rx_dv_d   = 1'b1;
        end
        // the first shift edge of each byte keeps bit 7 on the line instead of advancing
        if (active && shift && (cnt_q != 3'd0))
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        if (load)
            tx_shift_d = hold_valid_q ? hold_q : TX_IDLE_BYTE;
        if (active && cs_rise) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end
    end
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sck_q        <= {3{CPOL}};
            cs_q         <= 3'b111;
            mosi_q       <= 2'b00;
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            rx_shift_q   <= 8'h00;
            rx_byte_q    <= 8'h00;
            rx_dv_q      <= 1'b0;
            tx_shift_q   <= 8'h00;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
        end else begin
            sck_q        <= {sck_q[1:0], i_SPI_Clk};
            cs_q         <= {cs_q[1:0], i_SPI_CS_n};
            mosi_q       <= {mosi_q[0], i_SPI_MOSI};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_dv_q      <= rx_dv_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
    assign o_TX_Ready    = !hold_valid_q;
    assign o_RX_DV       = rx_dv_q;
    assign o_RX_Byte     = rx_byte_q;
    assign o_SPI_MISO    = active && tx_shift_q[7];
    assign o_SPI_MISO_En = active;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    logic underrun_q;
    always_ff @(posedge i_Clk) underrun_q <= i_Rst ? 1'b0 : (load && !hold_valid_q);
    assign o_TX_Underrun = underrun_q;
`endif
endmodule
